// File: rtl/frame_buffer_arbiter_if.sv
// Frame buffer arbiter bus: display/host requests and the memory command port.
// master = requester/memory side, slave = arbiter.
interface frame_buffer_arbiter_if #(
  parameter int ADDRESS_WIDTH = 25
);
  logic                     rd_req;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     rd_grant;
  logic                     wr_req;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [7:0]               wr_data;
  logic                     wr_grant;
  logic                     mem_valid;
  logic                     mem_wr;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_wdata;
  logic                     mem_full;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_full,
    input  rd_grant, wr_grant, mem_valid, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_full,
    output rd_grant, wr_grant, mem_valid, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Read/write arbiter for the frame buffer with write-starvation guard
// and frame-synchronous double-buffer swap.
module frame_buffer_arbiter #(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int MAX_READ_STREAK = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  frame_buffer_arbiter_if.slave bus,
  input  logic                  frame_done,
  input  logic                  swap_req,
  output logic                  frame_buffer_select,
  output logic                  swap_ack
);

  localparam int SW = $clog2(MAX_READ_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_READ_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [SW-1:0]   streak_q;
  logic            swap_pending_q;
  logic            can_grant;
  logic            wr_allowed;
  logic            starve;
  logic            rd_win;
  logic            wr_win;
  logic            do_swap;

  // Arbitration: reads first, unless the write has waited a full streak.
  always_comb begin
    can_grant  = reset_n && !bus.mem_full;
    wr_allowed = bus.wr_req && !swap_pending_q;
    starve     = (streak_q == STREAK_MAX) && wr_allowed;
    rd_win     = can_grant && bus.rd_req && !starve;
    wr_win     = can_grant && wr_allowed && (starve || !bus.rd_req);
  end

  // The state register doubles as the registered command strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      rd_win:  state_d = READ;
      wr_win:  state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_grant  = rd_win;
    bus.wr_grant  = wr_win;
    bus.mem_valid = (state_q != IDLE);
    bus.mem_wr    = (state_q == WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (rd_win) begin
      bus.mem_addr  <= bus.rd_addr;
      bus.mem_wdata <= '0;
    end else if (wr_win) begin
      bus.mem_addr  <= bus.wr_addr;
      bus.mem_wdata <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (rd_win) begin
      streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end else begin
      streak_q <= '0;
    end
  end

  // A swap requested in the frame_done cycle itself completes at once.
  assign do_swap = frame_done && (swap_pending_q || swap_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_pending_q      <= 1'b0;
      frame_buffer_select <= 1'b0;
      swap_ack            <= 1'b0;
    end else begin
      swap_ack <= do_swap;
      if (do_swap) begin
        frame_buffer_select <= ~frame_buffer_select;
        swap_pending_q      <= 1'b0;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: random and directed stimulus
// checked against a rule-level reference model.
module tb_frame_buffer_arbiter;
  localparam int AW   = 25;
  localparam int MAXS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_done = 1'b0;
  logic swap_req = 1'b0;
  logic frame_buffer_select;
  logic swap_ack;

  frame_buffer_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

  frame_buffer_arbiter #(
    .ADDRESS_WIDTH(AW),
    .MAX_READ_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .frame_done(frame_done),
    .swap_req(swap_req),
    .frame_buffer_select(frame_buffer_select),
    .swap_ack(swap_ack)
  );

  always #5 clk = ~clk;

  // {valid, wr, addr, wdata}
  typedef logic [AW+9:0] cmd_t;
  cmd_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  int m_streak;
  bit m_pend, m_sel, m_ack;
  bit exp_rd = 0, exp_wr = 0;
  bit act_rd, act_wr;
  int n_rd, n_wr, n_ack;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_streak = 0;
    m_pend   = 0;
    m_sel    = 0;
    m_ack    = 0;
    q.delete();
  endfunction

  task automatic step(input int p_rd, input int p_wr, input bit full,
                      input bit swp, input bit fd);
    cmd_t c;
    @(negedge clk);
    if (exp_rd) bus.rd_req = 1'b0;
    if (exp_wr) bus.wr_req = 1'b0;
    if (!bus.rd_req && $urandom_range(99) < p_rd) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'($urandom);
    end
    if (!bus.wr_req && $urandom_range(99) < p_wr) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'($urandom);
      bus.wr_data = 8'($urandom);
    end
    bus.mem_full = full;
    swap_req     = swp;
    frame_done   = fd;
    #4;
    chk("swap_ack", swap_ack, m_ack);
    chk("select", frame_buffer_select, m_sel);
    n_ack += int'(swap_ack);
    // Reads first; a write that has watched MAXS reads go by gets its turn.
    exp_rd = !full && bus.rd_req
             && !(m_streak >= MAXS && bus.wr_req && !m_pend);
    exp_wr = !full && bus.wr_req && !m_pend && !exp_rd;
    act_rd = bus.rd_grant;
    act_wr = bus.wr_grant;
    chk("rd_grant", act_rd, exp_rd);
    chk("wr_grant", act_wr, exp_wr);
    n_rd += int'(act_rd);
    n_wr += int'(act_wr);
    if (exp_rd)
      c = {1'b1, 1'b0, bus.rd_addr, 8'h00};
    else if (exp_wr)
      c = {1'b1, 1'b1, bus.wr_addr, bus.wr_data};
    else
      c = '0;
    q.push_back(c);
    m_streak = exp_rd ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    m_ack = fd && (m_pend || swp);
    if (m_ack) begin
      m_sel  = !m_sel;
      m_pend = 0;
    end else if (swp) begin
      m_pend = 1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, bus.mem_valid, 0);
    chk({tag, "_mem_wr"}, bus.mem_wr, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_select"}, frame_buffer_select, 0);
    chk({tag, "_swap_ack"}, swap_ack, 0);
    chk({tag, "_rd_grant"}, bus.rd_grant, 0);
    chk({tag, "_wr_grant"}, bus.wr_grant, 0);
  endtask

  // Monitor: one expected entry per stepped cycle.
  initial begin
    cmd_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && q.size() > 0) begin
        e = q.pop_front();
        if (e[AW+9])
          chk("mem_cmd", {bus.mem_valid, bus.mem_wr, bus.mem_addr,
                          bus.mem_wdata}, e);
        else
          chk("mem_valid_idle", bus.mem_valid, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pr, pw;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.mem_full = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = AW'(12'h0A0);
    #1;
    chk_reset_outputs("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(0, 0, 0, 0, 0);
    chk("single_rd_grant", act_rd, 1);
    @(posedge clk);
    #2;
    chk("single_rd_valid", bus.mem_valid, 1);
    chk("single_rd_wr", bus.mem_wr, 0);
    chk("single_rd_addr", bus.mem_addr, 64'h0A0);
    repeat (3) step(0, 0, 0, 0, 0);

    step(0, 0, 1, 0, 0);
    n_rd = 0;
    n_wr = 0;
    repeat (34) step(100, 100, 0, 0, 0);
    chk("streak_rd_count", n_rd, 32);
    chk("streak_wr_count", n_wr, 2);

    n_rd = 0;
    n_wr = 0;
    repeat (5) step(100, 100, 1, 0, 0);
    chk("full_no_grants", n_rd + n_wr, 0);
    step(100, 100, 0, 0, 0);
    chk("full_release_rd", act_rd, 1);

    step(0, 100, 0, 1, 0);
    n_wr = 0;
    repeat (19) step(0, 100, 0, 0, 0);
    chk("swap_blocks_wr", n_wr, 0);
    step(0, 100, 0, 0, 1);
    n_ack = 0;
    step(0, 100, 0, 0, 0);
    chk("swap_ack_once", n_ack, 1);
    chk("swap_select", frame_buffer_select, 1);
    chk("wr_resumes", act_wr, 1);

    n_ack = 0;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("double_swap_acks", n_ack, 2);
    chk("double_swap_select", frame_buffer_select, 1);

    repeat (5) step(100, 0, 0, 0, 0);
    step(100, 0, 0, 1, 0);
    step(100, 100, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    bus.rd_req = 1'b1;
    #1;
    chk_reset_outputs("async");
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_valid", bus.mem_valid, 0);
    chk("reset_hold_rd_grant", bus.rd_grant, 0);
    reset_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    step(100, 100, 0, 0, 0);
    chk("post_reset_rd", act_rd, 1);
    n_wr = 0;
    repeat (16) step(100, 100, 0, 0, 0);
    chk("post_reset_streak_wr", n_wr, 1);

    for (int b = 0; b < 30; b++) begin
      pr = int'($urandom_range(100));
      pw = int'($urandom_range(100));
      repeat (100)
        step(pr, pw, $urandom_range(99) < 15, $urandom_range(99) < 4,
             $urandom_range(99) < 4);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 25, width of all memory addresses.
REQ-002 Parameter MAX_READ_STREAK, default 16, maximum consecutive read grants while a write waits.
REQ-003 clk  input  1  Single clock for all logic.
REQ-004 reset_n  input  1  Asynchronous, active-low reset.
REQ-005 rd_req  input  1  Display loader read request; held until rd_grant.
REQ-006 rd_addr  input  ADDRESS_WIDTH  Read address; stable while rd_req=1.
REQ-007 rd_grant  output  1  Read accepted this cycle; combinational.
REQ-008 wr_req  input  1  Host write request; held until wr_grant.
REQ-009 wr_addr  input  ADDRESS_WIDTH  Write address; stable while wr_req=1.
REQ-010 wr_data  input  8  Write pixel byte (RGB 3-3-2).
REQ-011 wr_grant  output  1  Write accepted this cycle; combinational.
REQ-012 mem_valid  output  1  Registered command strobe to memory FIFO.
REQ-013 mem_wr  output  1  1=write, 0=read; valid with mem_valid.
REQ-014 mem_addr  output  ADDRESS_WIDTH  Registered command address.
REQ-015 mem_wdata  output  8  Registered write data; 0 on reads.
REQ-016 mem_full  input  1  Memory FIFO full; no grant issued while 1.
REQ-017 frame_done  input  1  One-cycle pulse at display frame wrap (line 15 -> 0).
REQ-018 swap_req  input  1  One-cycle pulse from host requesting buffer swap.
REQ-019 frame_buffer_select  output  1  Front buffer currently displayed.
REQ-020 swap_ack  output  1  One-cycle pulse when swap completes.

Function
REQ-021 At most one grant per cycle; no grant when mem_full=1.
REQ-022 Grant in cycle N -> mem_valid=1 in N+1 with mem_addr/mem_wr/mem_wdata of granted request; mem_valid=0 in cycles following no grant.
REQ-023 State machine IDLE/READ/WRITE records last grant owner: READ on rd_grant, WRITE on wr_grant, IDLE on any no-grant cycle.
REQ-024 Priority: read wins over write unless the write-starvation rule applies.
REQ-025 Read-streak counter: increments on each rd_grant, saturates at MAX_READ_STREAK, clears on wr_grant or any cycle without rd_grant.
REQ-026 Starvation rule: streak == MAX_READ_STREAK and wr_req=1 and writes enabled -> write granted, read waits.
REQ-027 swap_pending set on swap_req; while swap_pending=1, wr_grant forced 0 (host must not write back buffer mid-swap).
REQ-028 frame_done with swap_pending=1 (or swap_req in same cycle) -> frame_buffer_select toggles next cycle, swap_pending clears, swap_ack=1 for exactly that cycle.
REQ-029 frame_done with no pending swap -> no change, no swap_ack.
REQ-030 swap_req while swap_pending=1 -> ignored (single swap, single ack).
REQ-031 mem_full rising mid-streak -> streak counter clears (no-grant cycle), mem_valid=0 from next cycle.
REQ-032 Grants never depend on frame_done; reads continue through swap.

Reset
REQ-033 While reset_n=0: mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, frame_buffer_select=0, swap_ack=0, swap_pending=0, streak=0, state=IDLE.
REQ-034 rd_grant/wr_grant=0 during reset regardless of inputs; reset mid-transaction discards it, no pending command replayed.

Verification
REQ-035 rd_req=1 rd_addr=0x0A0, mem_full=0 -> rd_grant cycle N; mem_valid=1 mem_wr=0 mem_addr=0x0A0 cycle N+1.
REQ-036 rd_req and wr_req held continuously, MAX_READ_STREAK=16 -> 16 rd_grants, 1 wr_grant, repeating pattern.
REQ-037 mem_full=1 for 5 cycles with both requests -> no grants, mem_valid=0; first grant after release is read.
REQ-038 swap_req pulse, wr_req held, frame_done 20 cycles later -> wr_grant=0 for those cycles; frame_buffer_select 0->1 and swap_ack pulse cycle after frame_done; writes resume.
REQ-039 swap_req and frame_done same cycle -> select toggles next cycle, one swap_ack; second swap_req before frame_done ignored.
REQ-040 reset_n low during streak and pending swap -> all outputs at REQ-033 values asynchronously; after release first grant is read with streak=1.
